// File: rtl/chan_dump_ctrl.sv
// chan_dump_ctrl: streams one captured channel RAM to the UART transmitter.
// Reads the circular buffer oldest-first from the capture write pointer and
// sends exactly ENTRIES bytes, handshaking each one with trmt/tx_done.
// Optional feature macro: DUMP_HDR_EN. When defined, a header byte
// {5'b10000, chan} goes out before the data bytes.
module chan_dump_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump,
    input  logic [2:0]      dump_chan,
    input  logic            capt_done,
    input  logic [LOG2-1:0] start_addr,
    input  logic [7:0]      rdataCH1,
    input  logic [7:0]      rdataCH2,
    input  logic [7:0]      rdataCH3,
    input  logic [7:0]      rdataCH4,
    input  logic [7:0]      rdataCH5,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            busy,
    output logic            dump_done,
    output logic            dump_err
);

    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   ENT_EXT  = (LOG2 + 1)'(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_SEND,
`ifdef DUMP_HDR_EN
        S_HDR,
        S_HWAIT,
`endif
        S_WAITTX
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_chan;
    logic [LOG2-1:0] r_raddr;
    logic [LOG2-1:0] r_cnt;
    logic [7:0]      r_tx_data;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [7:0]      w_rdata;
    logic [LOG2-1:0] w_start;
    logic            w_req_ok;
    logic            w_accept;
    logic            w_reject;
    logic            w_last;
    logic            w_trmt;

    // A request is only honoured from IDLE; requests while busy are dropped silently.
    assign w_req_ok = capt_done && (dump_chan <= 3'd4);
    assign w_accept = (r_state == S_IDLE) && dump && w_req_ok;
    assign w_reject = (r_state == S_IDLE) && dump && !w_req_ok;
    assign w_last   = (r_cnt == LAST_IDX);
    // A write pointer beyond the buffer cannot be a real sample; start from 0.
    assign w_start  = ({1'b0, start_addr} >= ENT_EXT) ? '0 : start_addr;

    // Select read data of the channel latched at acceptance
    always_comb begin
        w_rdata = 8'h00;
        case (r_chan)
            3'd0:    w_rdata = rdataCH1;
            3'd1:    w_rdata = rdataCH2;
            3'd2:    w_rdata = rdataCH3;
            3'd3:    w_rdata = rdataCH4;
            3'd4:    w_rdata = rdataCH5;
            default: w_rdata = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef DUMP_HDR_EN
                if (w_accept) w_state_next = S_HDR;
`else
                if (w_accept) w_state_next = S_RD;
`endif
            end
`ifdef DUMP_HDR_EN
            S_HDR:   w_state_next = S_HWAIT;
            S_HWAIT: if (tx_done) w_state_next = S_RD;
`endif
            S_RD:    w_state_next = S_LAT;
            S_LAT:   w_state_next = S_SEND;
            S_SEND:  w_state_next = S_WAITTX;
            S_WAITTX: begin
                if (tx_done) w_state_next = w_last ? S_IDLE : S_RD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: address/count stepping, byte capture and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan    <= 3'd0;
            r_raddr   <= '0;
            r_cnt     <= '0;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            if (w_accept) begin
                r_chan  <= dump_chan;
                r_raddr <= w_start;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
`ifdef DUMP_HDR_EN
                r_tx_data <= {5'b10000, dump_chan};
`endif
            end
            if (r_state == S_LAT) begin
                r_tx_data <= w_rdata;
            end
            if (r_state == S_WAITTX && tx_done) begin
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_raddr <= (r_raddr == LAST_IDX) ? '0 : r_raddr + 1'b1;
                end
            end
        end
    end

    // Output logic: trmt is high for the single cycle spent in a send state
    always_comb begin
        w_trmt = (r_state == S_SEND);
`ifdef DUMP_HDR_EN
        if (r_state == S_HDR) w_trmt = 1'b1;
`endif
    end

    assign raddr     = r_raddr;
    assign tx_data   = r_tx_data;
    assign trmt      = w_trmt;
    assign busy      = r_busy;
    assign dump_done = r_done;
    assign dump_err  = r_err;

endmodule

// File: tb/tb_chan_dump_ctrl.sv
// Bench for chan_dump_ctrl: channel RAM models, a transmitter model that
// answers each trmt with tx_done 10 cycles later, and a byte scoreboard.
module tb_chan_dump_ctrl;

    localparam int ENT  = 384;
    localparam int LOG2 = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dump;
    logic [2:0]      dump_chan;
    logic            capt_done;
    logic [LOG2-1:0] start_addr;
    logic [7:0]      rd [5];
    logic [LOG2-1:0] raddr;
    logic [7:0]      tx_data;
    logic            trmt;
    logic            tx_done;
    logic            busy;
    logic            dump_done;
    logic            dump_err;

    logic [7:0]      mem [5][ENT];
    logic [7:0]      exp_q [$];
    int              total = 0;
    int              bad   = 0;

    chan_dump_ctrl #(.ENTRIES(ENT), .LOG2(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .dump(dump), .dump_chan(dump_chan),
        .capt_done(capt_done), .start_addr(start_addr),
        .rdataCH1(rd[0]), .rdataCH2(rd[1]), .rdataCH3(rd[2]),
        .rdataCH4(rd[3]), .rdataCH5(rd[4]),
        .raddr(raddr), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .busy(busy), .dump_done(dump_done), .dump_err(dump_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs with one-cycle read latency
    always @(posedge clk) begin
        for (int ch = 0; ch < 5; ch++)
            rd[ch] <= (int'(raddr) < ENT) ? mem[ch][raddr] : 8'hxx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int ch, input int mode);
        for (int i = 0; i < ENT; i++) begin
            case (mode)
                0:       mem[ch][i] = 8'h00;
                1:       mem[ch][i] = i[7:0];
                2:       mem[ch][i] = 8'hA5;
                default: mem[ch][i] = 8'((i * 3 + 7) & 255);
            endcase
        end
    endtask

    // Model of the byte stream an accepted dump must produce
    task automatic push_dump(input int ch, input int start);
        int s;
        s = (start >= ENT) ? 0 : start;
`ifdef DUMP_HDR_EN
        exp_q.push_back({5'b10000, 3'(ch)});
`endif
        for (int i = 0; i < ENT; i++) exp_q.push_back(mem[ch][(s + i) % ENT]);
    endtask

    // Called at a negedge right after raising dump. Serves nbytes trmt
    // pulses, checking latency and data; optionally completes the dump.
    task automatic serve(input int nbytes, input bit finish, input bit disturb);
        int got = 0, cyc = 0, lat = 0, txcnt = -1;
        int done_seen = 0, err_seen = 0, extra = 0;
        int exp_lat;
        logic [7:0] exp_b;
`ifdef DUMP_HDR_EN
        exp_lat = 1;
`else
        exp_lat = 3;
`endif
        while (got < nbytes && cyc < nbytes * 20 + 100) begin
            @(negedge clk);
            cyc++; lat++;
            dump = 1'b0; tx_done = 1'b0;
            done_seen += int'(dump_done);
            err_seen  += int'(dump_err);
            if (trmt) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("latency", lat, exp_lat);
                check("byte", tx_data, exp_b);
                check("busy_during", busy, 1);
                exp_lat = 3;
                got++;
                txcnt = 10;
                if (disturb && got == 5) begin
                    dump = 1'b1; dump_chan = 3'd3; start_addr = '0; capt_done = 1'b0;
                end
            end else if (txcnt > 0) begin
                txcnt--;
                if (txcnt == 0) begin tx_done = 1'b1; lat = 0; end
            end
        end
        check("byte_count", got, nbytes);
        check("no_early_done", done_seen, 0);
        check("no_err_busy", err_seen, 0);
        if (finish) begin
            while (txcnt > 0) begin
                @(negedge clk);
                tx_done = 1'b0;
                extra += int'(trmt);
                txcnt--;
                if (txcnt == 0) tx_done = 1'b1;
            end
            @(negedge clk);
            tx_done = 1'b0;
            check("done_pulse", dump_done, 1);
            check("busy_end", busy, 0);
            @(negedge clk);
            check("done_once", dump_done, 0);
            repeat (6) begin
                @(negedge clk);
                extra += int'(trmt);
            end
            check("no_extra_trmt", extra, 0);
            check("queue_empty", exp_q.size(), 0);
        end
    endtask

    task automatic start_dump(input int ch, input int start, input bit model);
        dump_chan  = 3'(ch);
        start_addr = LOG2'(start);
        if (model) push_dump(ch, start);
        dump = 1'b1;
    endtask

    task automatic reject_case(input int ch, input bit cd);
        int tr = 0;
        capt_done = cd;
        dump_chan = 3'(ch);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        check("err_pulse", dump_err, 1);
        @(negedge clk);
        check("err_once", dump_err, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            tr += int'(trmt) + int'(busy);
        end
        check("reject_idle", tr, 0);
        $display("reject chan=%0d capt_done=%0d", ch, cd);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; dump = 1'b0; dump_chan = 3'd0; capt_done = 1'b1;
        start_addr = '0; tx_done = 1'b0;
        for (int c = 0; c < 5; c++) fill(c, 0);
        repeat (3) @(negedge clk);
        check("rst_raddr", raddr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_trmt", trmt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", dump_done, 0);
        check("rst_err", dump_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CH1 ramp, start 0
        fill(0, 1);
        start_dump(0, 0, 1);
        serve(ENT + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 1, 0);
        $display("dump chan=0 start=0");

        // CH1 ramp from 200: wrap 383->0; mid-dump request/input changes ignored
        start_dump(0, 200, 1);
        serve(ENT + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 1, 1);
        capt_done = 1'b1;
        $display("dump chan=0 start=200 (disturbed)");

        // CH5 constant, others zero
        fill(0, 0); fill(4, 2);
        start_dump(4, 0, 1);
        serve(ENT + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 1, 0);
        $display("dump chan=4 start=0");

        // Rejected requests
        reject_case(6, 1'b1);
        reject_case(0, 1'b0);
        capt_done = 1'b1;

        // Abort by reset after byte 50, then clean re-dump of CH2 from 10
        fill(1, 3); fill(0, 1);
        start_dump(1, 10, 1);
        serve(51 + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_trmt", trmt, 0);
        @(negedge clk);
        check("abort_raddr", raddr, 0);
        check("abort_tx_data", tx_data, 0);
        exp_q.delete();
        rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            dn += int'(dump_done) + int'(trmt) + int'(busy);
        end
        check("abort_quiet", dn, 0);
        $display("dump chan=1 start=10 aborted by reset");
        start_dump(1, 10, 1);
        serve(ENT + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 1, 0);
        $display("dump chan=1 start=10");

        // Out-of-range start pointer behaves as 0
        start_dump(0, 450, 1);
        serve(ENT + `ifdef DUMP_HDR_EN 1 `else 0 `endif, 1, 0);
        $display("dump chan=0 start=450");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_dump_ctrl.md
Name: chan_dump_ctrl

Overview:
- Streams one captured channel RAM to the host as a sequence of UART bytes after a dump command.
- Sits downstream of the capture block and channel RAMs, and upstream of the UART transmitter inside LA_dig.
- Reads the circular sample buffer oldest-first, starting at the capture write pointer, and issues exactly ENTRIES bytes.
- Handshakes each byte with the transmitter (trmt/tx_done).

Parameters:
ENTRIES, 384, number of RAM entries per channel (12288 on DE-0)
LOG2, 9, address width; must satisfy 2**LOG2 >= ENTRIES

Ports:
clk  in  1  system clock (100MHz)
rst_n  in  1  asynchronous active-low reset
dump  in  1  one-cycle pulse; start dump of dump_chan
dump_chan  in  3  channel select: 0..4 = CH1..CH5; 5..7 invalid
capt_done  in  1  capture complete; dump is only legal when high
start_addr  in  LOG2  address of the oldest sample (capture write pointer)
rdataCH1..rdataCH5  in  8 each  synchronous RAM read data, 1-cycle latency
raddr  out  LOG2  RAM read address, shared by all channel RAMs
tx_data  out  8  byte to transmit
trmt  out  1  one-cycle pulse; start transmission of tx_data
tx_done  in  1  transmitter finished the current byte
busy  out  1  high while a dump is in progress
dump_done  out  1  one-cycle pulse after the last byte's tx_done
dump_err  out  1  one-cycle pulse when a dump request is rejected

Behaviour:
- Reset values: raddr=0, tx_data=0, trmt=0, busy=0, dump_done=0, dump_err=0, state=IDLE, byte count=0.
- States: IDLE, RD (address presented), LAT (RAM latency), SEND (pulse trmt), WAITTX.
- IDLE:
  - dump with valid chan and capt_done=1: latch chan, raddr<=start_addr, cnt<=0, busy<=1, go to RD (or HDR with DUMP_HDR_EN).
  - dump with chan>4 or capt_done=0: pulse dump_err next cycle; stay in IDLE.
- RD -> LAT. The RAM samples raddr at this edge.
- LAT:
  - tx_data <= rdata of the latched channel.
  - Go to SEND.
- SEND:
  - trmt=1 for exactly one cycle.
  - Go to WAITTX.
- WAITTX on tx_done:
  - If cnt==ENTRIES-1: busy<=0, dump_done pulse, go to IDLE.
  - Otherwise: cnt<=cnt+1, raddr<=(raddr==ENTRIES-1)?0:raddr+1, go to RD.
- Address wrap:
  - The increment wraps at ENTRIES-1, not at 2**LOG2-1.
  - start_addr >= ENTRIES is treated as 0.
- Per-byte latency: from tx_done to the next trmt is 3 clocks (RD, LAT, SEND).
- First trmt is 3 clocks after the dump pulse.
- dump asserted while busy: ignored; no error pulse; the dump in progress is unaffected.
- tx_done outside WAITTX: ignored.
- start_addr, dump_chan and capt_done are sampled only at dump acceptance; later changes have no effect.
- rst_n asserted mid-dump: immediate return to reset values; no dump_done; the next dump starts cleanly.
- Exactly ENTRIES trmt pulses per accepted dump (ENTRIES+1 with DUMP_HDR_EN).

Optional Feature:
- Macro: DUMP_HDR_EN.
- Defined:
  - After acceptance, an extra state HDR sends one header byte {5'b10000, chan}, handshaked like data bytes.
  - Data bytes follow the header.
  - First data trmt occurs 3 clocks after the header's tx_done.
- Undefined:
  - HDR state is absent.
  - Only data bytes are sent; behaviour is exactly as above.

Test Plan:
- Preload CH1 RAM with mem[i]=i[7:0]; start_addr=0; capt_done=1; dump chan=0; bench model returns tx_done 10 cycles after each trmt -> 384 bytes 0x00..0xFF,0x00..0x7F in order; one dump_done; busy low afterwards.
- Same data with start_addr=200 -> first byte 0xC8, byte 183 is 0x7F, byte 184 is 0x00 (wrap at 383->0), last byte 0xC7.
- dump chan=4 with CH5 holding 0xA5 everywhere and other RAMs 0x00 -> all 384 bytes 0xA5.
- dump chan=6, then dump chan=0 with capt_done=0 -> a dump_err pulse for each, no trmt, busy stays 0.
- Assert rst_n low after byte 50 of a dump, release, re-dump chan=1 with start_addr=10 -> full 384-byte stream starting at mem[10]; no dump_done for the aborted run.
- With DUMP_HDR_EN, dump chan=2 -> first byte 0x82, then 384 data bytes; 385 trmt pulses total.
